// File: rtl/input_port_pkg.sv
`default_nettype none
// ============================================================================
// Package  : input_port_pkg
// Purpose  : Status-word bit positions and sizing helper for input_port_buffer.
// Revision : 1.0
// ============================================================================
package input_port_pkg;

  // Flag positions are offsets below the MSB so they track any DATA_WIDTH.
  localparam int STAT_OVF     = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_CNT_LSB = 0;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inport_fifo.sv
`default_nettype none
// ============================================================================
// Module   : inport_fifo
// Purpose  : Small circular FIFO with occupancy count; storage is not reset.
// Revision : 1.0
// ============================================================================
module inport_fifo
  import input_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CW         = count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CW-1:0]         o_count,
  output logic [DATA_WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == c_depth);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // Internal guards keep pointers coherent even if a caller misbehaves.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= AW'(r_wptr + 1'b1);
      end
      if (w_pop) begin
        r_rptr <= AW'(r_rptr + 1'b1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= CW'(r_count + 1'b1);
        2'b01:   r_count <= CW'(r_count - 1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/input_port_buffer.sv
`default_nettype none
// ============================================================================
// Module   : input_port_buffer
// Purpose  : Device-to-bus input port: handshake, FIFO, sticky overflow, status.
// Revision : 1.0
// ============================================================================
module input_port_buffer
  import input_port_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_strobe,
  output logic                  in_ready,
  input  logic                  InPortout,
  input  logic                  StatusOut,
  output logic [DATA_WIDTH-1:0] BusMuxIn_InPort,
  output logic                  data_avail,
  output logic                  in_overflow
);

  localparam int CW = count_width(DEPTH);

  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_status;
  logic                  r_overflow;

  assign in_ready    = !w_full;
  assign data_avail  = !w_empty;
  assign in_overflow = r_overflow;

  assign w_push = in_strobe && !w_full;
  assign w_drop = in_strobe &&  w_full;
  // A status read takes the bus, so it suppresses the pop.
  assign w_pop  = InPortout && !StatusOut && !w_empty;

  inport_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .CW         (CW)
  ) u_fifo (
    .clk     (clock),
    .rst     (clear),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (StatusOut) begin
      r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_status = '0;
    w_status[DATA_WIDTH-1-STAT_OVF]   = r_overflow;
    w_status[DATA_WIDTH-1-STAT_EMPTY] = w_empty;
    w_status[DATA_WIDTH-1-STAT_FULL]  = w_full;
    w_status[STAT_CNT_LSB +: CW]      = w_count;
  end

  always_comb begin
    BusMuxIn_InPort = '0;
    if (StatusOut) begin
      BusMuxIn_InPort = w_status;
    end else if (InPortout && !w_empty) begin
      BusMuxIn_InPort = w_head;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_input_port_buffer.sv
`default_nettype none
// Testbench for input_port_buffer: queue-based reference model checked every
// cycle, plus directed sequences with literal expectations.
module tb_input_port_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clock;
  logic          clear;
  logic [DW-1:0] in_data;
  logic          in_strobe;
  logic          in_ready;
  logic          InPortout;
  logic          StatusOut;
  logic [DW-1:0] BusMuxIn_InPort;
  logic          data_avail;
  logic          in_overflow;

  int n_checks = 0;
  int n_errors = 0;

  input_port_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .clear           (clear),
    .in_data         (in_data),
    .in_strobe       (in_strobe),
    .in_ready        (in_ready),
    .InPortout       (InPortout),
    .StatusOut       (StatusOut),
    .BusMuxIn_InPort (BusMuxIn_InPort),
    .data_avail      (data_avail),
    .in_overflow     (in_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a queue of words plus the sticky overflow flag.
  logic [DW-1:0] m_q[$];
  logic          m_ovf;

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      automatic bit full  = (m_q.size() == DEPTH);
      automatic bit push  = in_strobe && !full;
      automatic bit drop  = in_strobe && full;
      automatic bit pop   = InPortout && !StatusOut && (m_q.size() != 0);
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(in_data);
      if (drop) m_ovf = 1'b1;
      else if (StatusOut) m_ovf = 1'b0;
    end
  end

  function automatic logic [DW-1:0] model_bus();
    logic [DW-1:0] st;
    st = DW'(m_q.size());
    if (m_q.size() == 0)     st = st | (DW'(1) << (DW-2));
    if (m_q.size() == DEPTH) st = st | (DW'(1) << (DW-3));
    if (m_ovf)               st = st | (DW'(1) << (DW-1));
    if (StatusOut) return st;
    if (InPortout && m_q.size() != 0) return m_q[0];
    return '0;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  bit model_on = 1'b0;
  always @(negedge clock) begin
    if (model_on && !clear) begin
      check("m_ready", DW'(in_ready),    DW'(m_q.size() != DEPTH));
      check("m_avail", DW'(data_avail),  DW'(m_q.size() != 0));
      check("m_ovf",   DW'(in_overflow), DW'(m_ovf));
      check("m_bus",   BusMuxIn_InPort,  model_bus());
    end
  end

  // Apply inputs just after a rising edge; they are sampled at the next one.
  task automatic step(input logic s, input logic [DW-1:0] d, input logic rd, input logic st);
    in_strobe = s; in_data = d; InPortout = rd; StatusOut = st;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  initial begin
    step(0, '0, 0, 0);
    clear = 1'b1;
    #12;
    @(negedge clock); clear = 1'b0;
    @(posedge clock); #1;
    model_on = 1'b1;

    // Reset state
    check("rst_ready", DW'(in_ready), 1);
    check("rst_avail", DW'(data_avail), 0);
    check("rst_ovf",   DW'(in_overflow), 0);
    check("rst_bus",   BusMuxIn_InPort, 0);

    // Three pushes then three reads, in order
    step(1, 32'hA, 0, 0); tick();
    step(1, 32'hB, 0, 0); tick();
    step(1, 32'hC, 0, 0); tick();
    step(0, '0, 1, 0); #1; check("rd0", BusMuxIn_InPort, 32'hA); tick();
    check("rd1", BusMuxIn_InPort, 32'hB); tick();
    check("rd2", BusMuxIn_InPort, 32'hC); tick();
    check("avail_fall", DW'(data_avail), 0);
    check("ovf_still0", DW'(in_overflow), 0);

    // Read while empty: bus 0, nothing changes
    check("empty_rd_bus", BusMuxIn_InPort, 0); tick();
    step(0, '0, 0, 1); #1;
    check("empty_status", BusMuxIn_InPort, 32'h4000_0000); tick();

    // Five strobes into a depth-4 FIFO: fifth is dropped
    for (int i = 1; i <= 5; i++) begin
      step(1, DW'(i), 0, 0); tick();
      if (i == 4) check("ready_drop", DW'(in_ready), 0);
    end
    // Status read coinciding with another drop: flag stays set
    step(1, 32'h66, 0, 1); #1;
    check("full_status", BusMuxIn_InPort, 32'hA000_0004); tick();
    check("ovf_kept", DW'(in_overflow), 1);
    step(0, '0, 0, 1); tick();
    check("ovf_cleared", DW'(in_overflow), 0);
    step(0, '0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      #1; check("drain", BusMuxIn_InPort, DW'(i)); tick();
    end

    // Push+pop every cycle at count 2, across several pointer wraps
    step(1, 32'h10, 0, 0); tick();
    step(1, 32'h11, 0, 0); tick();
    for (int i = 0; i < 10; i++) begin
      step(1, DW'(32'h12 + i), 1, 0); #1;
      check("stream", BusMuxIn_InPort, DW'(32'h10 + i)); tick();
    end
    step(0, '0, 0, 1); #1;
    check("stream_cnt", BusMuxIn_InPort, 32'h0000_0002); tick();
    step(0, '0, 1, 0); #1; check("tail0", BusMuxIn_InPort, 32'h1A); tick();
    #1; check("tail1", BusMuxIn_InPort, 32'h1B); tick();
    step(0, '0, 0, 0);

    // Asynchronous clear between edges with three words buffered
    step(1, 32'h21, 0, 0); tick();
    step(1, 32'h22, 0, 0); tick();
    step(1, 32'h23, 0, 0); tick();
    step(0, '0, 0, 0);
    #1; clear = 1'b1; #1;
    check("clr_ready", DW'(in_ready), 1);
    check("clr_avail", DW'(data_avail), 0);
    check("clr_ovf",   DW'(in_overflow), 0);
    clear = 1'b0;
    tick();
    step(1, 32'h5, 0, 0); tick();
    step(0, '0, 1, 0); #1;
    check("post_clr", BusMuxIn_InPort, 32'h5); tick();
    step(0, '0, 0, 0); tick(); tick();

    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input_port_buffer.md
# input_port_buffer

Receive-side counterpart of the CPU output port: it accepts words from an external input device through a valid/ready handshake and buffers them in a small FIFO. The datapath then reads them onto the bus one word per `InPortout` strobe. A status word (occupancy, empty, full, sticky overflow) can also be driven onto the bus, so software can poll the device. The block sits beside the register file as one more source feeding the bus multiplexer.

## Interface
- `DATA_WIDTH`, 32, width of device data and of the bus word; must be ≥ 8.
- `DEPTH`, 4, number of FIFO entries; must be a power of two and ≥ 2.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `clear`  in  1  asynchronous, active-high reset.
- `in_data`  in  DATA_WIDTH  word from the external device.
- `in_strobe`  in  1  device asserts: `in_data` is valid this cycle.
- `in_ready`  out  1  block can accept a word this cycle.
- `InPortout`  in  1  control unit reads the head word and pops it.
- `StatusOut`  in  1  control unit reads the status word.
- `BusMuxIn_InPort`  out  DATA_WIDTH  value presented to the bus multiplexer.
- `data_avail`  out  1  FIFO is non-empty.
- `in_overflow`  out  1  sticky flag: a word was dropped.

## Operation
- Occupancy `count` ranges 0..DEPTH and is `$clog2(DEPTH)+1` bits wide.
- The read and write pointers are `$clog2(DEPTH)` bits wide and wrap naturally modulo DEPTH.

Push:
- A push occurs on an edge where `in_strobe && in_ready`.
- `in_data` is written at the write pointer, and the write pointer increments.

Drop:
- A drop occurs on an edge where `in_strobe && !in_ready`.
- Nothing is stored, and `in_overflow` is set.

Pop:
- A pop occurs on an edge where `InPortout && !StatusOut && count != 0`.
- The read pointer increments.
- `InPortout` while empty does nothing to state and puts 0 on the bus.

Count update:
- Push and pop on the same edge: both occur and `count` is unchanged. This is legal only when 0 < count < DEPTH.
- When full, `in_ready` is 0, so no push can coincide with a pop.

Bus output (combinational from registered state):
- If `StatusOut`: the status word.
- Else if `InPortout` and non-empty: the FIFO head.
- Else: 0.

Status word:
- Bit DATA_WIDTH-1 = `in_overflow`.
- Bit DATA_WIDTH-2 = empty.
- Bit DATA_WIDTH-3 = full.
- Bits `[$clog2(DEPTH):0]` = `count`.
- All other bits are 0.

Status read:
- Any edge with `StatusOut` high clears `in_overflow`.
- A drop on the same edge wins: the flag stays set.
- `StatusOut` together with `InPortout`: the status word is presented and no pop occurs.

Ready and available:
- `in_ready = (count != DEPTH)`.
- `data_avail = (count != 0)`.
- Both are derived from registered state only, with no combinational path from any input.

## Timing
- Reset state: `count`, both pointers and `in_overflow` are 0. Therefore `in_ready`=1, `data_avail`=0, `in_overflow`=0, and `BusMuxIn_InPort`=0 while the selects are low.
- Storage contents are not reset and are never visible while empty.
- Latency: a word pushed at edge N is readable on the bus in the cycle after N (`data_avail` rises after edge N).
- A pop at edge N exposes the next entry in the cycle after N.
- Throughput: one push and one pop per cycle.
- The FIFO preserves order, including across pointer wrap-around.
- `clear` asserted mid-transfer immediately empties the FIFO and clears overflow, independent of `clock`; words in flight are discarded.
- The first edge after `clear` deasserts behaves as the first cycle after reset.

## Structure
- Package `input_port_pkg` holds the status bit-position constants (`STAT_OVF`, `STAT_EMPTY`, `STAT_FULL`, count LSB) and a function computing the count width from DEPTH.
- Sub-module `inport_fifo` contains the storage array, pointers and count, with push/pop/full/empty/head ports.
- The top level adds the handshake, the overflow flag and the bus output mux.

## Test plan
- Reset, then 3 pushes (0xA, 0xB, 0xC), then 3 `InPortout` reads → bus shows 0xA, 0xB, 0xC in order; `data_avail` falls after the third pop; overflow stays 0.
- 5 consecutive strobes with DEPTH=4 → `in_ready` drops after the 4th push; the 5th word is dropped; the status read returns overflow=1, full=1, count=4.
- Simultaneous push and pop at count=2 for 10 cycles with incrementing data → count holds at 2; data is read back in order across multiple pointer wraps.
- `InPortout` when empty → bus 0; `count`, pointers and flags unchanged.
- Overflow set, then `StatusOut` on a cycle with a concurrent drop → flag remains 1; the next `StatusOut` without a drop clears it to 0.
- `clear` pulsed between clock edges while count=3 → count=0, `in_ready`=1, `data_avail`=0 immediately; a subsequent push of 0x5 reads back as 0x5.
